// File: rtl/uart_rx_buffer.sv
// Receive-side buffer behind a UART receiver. It captures one 9-bit frame per rising
// edge of Rx_done and checks parity. Good bytes go into a first-word fall-through FIFO;
// parity failures are counted and a full FIFO sets a sticky overflow flag.
module uart_rx_buffer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ERRCNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        PARITYSEL_Rx,
   input  logic                        Rx_done,
   input  logic [8:0]                  Rx_d_out,
   output logic                        Rd_valid,
   input  logic                        Rd_ready,
   output logic [7:0]                  Rd_data,
   output logic [$clog2(FIFO_DEPTH):0] Fifo_level,
   output logic                        Overflow,
   input  logic                        Err_clr,
   output logic [ERRCNT_W-1:0]         ERRCOUNTER
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {CAP_IDLE, CAP_BAD, CAP_PUSH, CAP_OVFL} cap_act_e;

   logic                rx_done_q;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [LVL_W-1:0]    level;
   logic [7:0]          mem [FIFO_DEPTH];
   logic                ovf_q;
   logic [ERRCNT_W-1:0] err_cnt;

   logic     cap;
   logic     parity_ok;
   logic     pop;
   logic     space;
   logic     push;
   cap_act_e cap_act;

   assign cap       = Rx_done & ~rx_done_q;
   assign parity_ok = ((^Rx_d_out) == PARITYSEL_Rx);
   assign pop       = Rd_valid & Rd_ready;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
   assign space     = (level < LVL_W'(FIFO_DEPTH)) | pop;

   always_comb begin
      // NOTE: default first so every path assigns cap_act and no latch is inferred.
      cap_act = CAP_IDLE;
      if (cap) begin
         if (!parity_ok)
            cap_act = CAP_BAD;
         else if (space)
            cap_act = CAP_PUSH;
         else
            cap_act = CAP_OVFL;
      end
   end

   assign push = (cap_act == CAP_PUSH);

   // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_done_q <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
      end else begin
         rx_done_q <= Rx_done;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
      end
   end

   // NOTE: storage has no reset; the level counter alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= Rx_d_out[7:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovf_q   <= 1'b0;
         err_cnt <= '0;
      end else if (Err_clr) begin
         ovf_q   <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (cap_act == CAP_OVFL)
            ovf_q <= 1'b1;
         if (cap_act == CAP_BAD && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
      end
   end

   assign Rd_valid   = (level != '0);
   assign Rd_data    = mem[rd_ptr];
   assign Fifo_level = level;
   assign Overflow   = ovf_q;
   assign ERRCOUNTER = err_cnt;

endmodule
